riscv_div_unit: RTL and testbench
=================================

# riscv_div_unit

Iterative 32-bit RV32M divider (DIV, DIVU, REM, REMU) in the pipeline EX stage. One restoring step per cycle. Each step's trial subtraction feeds the codebase's 32-bit ripple adder (`full_adder_32bit`), using `Y_i` = ~divisor and `C_i` = 1. The block consumes that adder's `Sum_o`/`c_o` to pick the quotient bit and the next remainder. EX holds the instruction while `busy_o` is high; the result goes to the EX/MEM register on `valid_o`.

## Interface
- `XLEN`, 32: operand width; only 32 is legal, matching the adder width.
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `start_i` in 1: request; sampled only in IDLE.
- `op_i` in 2: funct3[1:0]; 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `rs1_i` in 32: dividend, sampled with `start_i`.
- `rs2_i` in 32: divisor, sampled with `start_i`.
- `kill_i` in 1: pipeline flush; synchronous abort.
- `busy_o` out 1: state != IDLE.
- `valid_o` out 1: one-cycle result strobe.
- `result_o` out 32: quotient (DIV/DIVU) or remainder (REM/REMU); registered, held until the next `valid_o`.

## Operation
- **States:** IDLE, PREP, ITER, FIX, DONE.
- **IDLE → PREP** on `start_i`:
  - latch `op_i`, `rs1_i`, `rs2_i`;
  - signed flag = ~`op_i`[0].
- **PREP → ITER:**
  - signed ops: D = |rs2|, Q = |rs1|, i.e. magnitudes as 32-bit unsigned, so |0x80000000| = 0x80000000;
  - unsigned ops: D = rs2, Q = rs1;
  - R = 0, count = 31;
  - record neg_q = sign(rs1)^sign(rs2), neg_r = sign(rs1), dz = (rs2 == 0).
- **ITER step:**
  - S = {R[30:0], Q[31]}, drive adder A_i = S, Y_i = ~D, C_i = 1;
  - q = R[31] | c_o;
  - R ← q ? Sum_o : S; Q ← {Q[30:0], q}; count decrements;
  - leave for FIX after the count = 0 step, i.e. exactly 32 steps.
- **FIX → DONE:**
  - quotient = (signed & neg_q & ~dz) ? −Q : Q;
  - remainder = (signed & neg_r) ? −R : R;
  - `result_o` ← quotient or remainder per `op_i`[1].
- **DONE:** `valid_o` = 1 for one cycle; then go to IDLE.
- **Special results (RISC-V):**
  - x/0: quotient 0xFFFFFFFF, remainder = dividend.
  - DIV 0x80000000/−1: quotient 0x80000000, remainder 0.
  - Without `DIV_FASTPATH_EN`, the datapath produces both through the normal 32 steps.
- **Boundaries:**
  - `start_i` while busy is ignored; no queueing.
  - `kill_i` in any non-IDLE state goes to IDLE next edge with no `valid_o`; `result_o` keeps its old value. `kill_i` in IDLE has no effect.
  - `kill_i` and `start_i` together in IDLE: `kill_i` wins, request dropped.
  - `rst_i` mid-operation: immediate IDLE.
- **Reset values:** state IDLE, `busy_o` 0, `valid_o` 0, `result_o` 0, internal R/Q/D/count 0.

## Timing
- `start_i` is accepted at edge E0, after which `busy_o` = 1.
- PREP completes at E1, ITER runs E2..E33, FIX at E34.
- `valid_o` = 1 and `result_o` is valid in the cycle after E34.
- DONE → IDLE at E35, when `busy_o` falls.
- Latency is 35 cycles from accept to `valid_o`; the next `start_i` can be accepted at E36.
- The adder path is purely combinational within one ITER cycle.

## Configuration
- **`DIV_FASTPATH_EN` defined:**
  - PREP detects divide-by-zero or signed overflow (DIV/REM, rs1 = 0x80000000, rs2 = 0xFFFFFFFF);
  - it loads the special result straight into `result_o` and goes PREP → DONE;
  - `valid_o` comes in the cycle after E1 (2-cycle latency).
  - All other operands are unchanged.
- **Not defined:** every op takes 35 cycles; special results come from the iteration plus the dz fix-up rule.

## Test plan
- DIVU 100/7: `valid_o` exactly 35 cycles after accept, `result_o` = 14. REMU 100/7 gives 2.
- Signed operands:
  - DIV −7/2 → 0xFFFFFFFD (−3);
  - REM −7/2 → 0xFFFFFFFF (−1);
  - DIV 7/−2 → 0xFFFFFFFD;
  - REM 7/−2 → 1.
- Divide by zero:
  - DIVU 5/0 → 0xFFFFFFFF;
  - DIV −5/0 → 0xFFFFFFFF;
  - REM −5/0 → 0xFFFFFFFB;
  - with `DIV_FASTPATH_EN`, latency 2 cycles.
- Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0. DIVU 0xFFFFFFFF/1 → 0xFFFFFFFF.
- Abort and ignore rules:
  - `kill_i` at ITER step 10: `busy_o` low next cycle, no `valid_o`, `result_o` unchanged;
  - a second `start_i` pulsed mid-op is ignored and the first result is correct.
- `rst_i` asserted asynchronously mid-ITER: `busy_o`, `valid_o`, `result_o` go to 0 immediately, with no strobe after release.

Source files
------------

// File: rtl/riscv_div_unit.sv
// riscv_div_unit: iterative RV32M divider (DIV, DIVU, REM, REMU) for the EX stage.
// Restoring division, one quotient bit per cycle. The trial subtraction of each
// step goes through full_adder_32bit as S + ~D + 1.
// Optional feature macro: DIV_FASTPATH_EN. When it is defined, divide-by-zero and
// signed overflow are resolved in PREP, giving a 2-cycle latency for those cases.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start_i; operands latched on accept
// PREP  | take magnitudes, record sign/zero flags, clear remainder
// ITER  | one restoring step per cycle, 32 steps
// FIX   | apply sign correction, register quotient or remainder
// DONE  | valid_o high for one cycle, then back to IDLE

module full_adder_32bit (
  input  logic [31:0] A_i,
  input  logic [31:0] Y_i,
  input  logic        C_i,
  output logic [31:0] Sum_o,
  output logic        c_o
);

  logic carry;

  // Ripple-carry sum, bit 0 upward.
  always_comb begin
    carry = C_i;
    Sum_o = '0;
    for (int k = 0; k < 32; k++) begin
      Sum_o[k] = A_i[k] ^ Y_i[k] ^ carry;
      carry    = (A_i[k] & Y_i[k]) | (carry & (A_i[k] ^ Y_i[k]));
    end
    c_o = carry;
  end

endmodule

module riscv_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            kill_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  state_t          state;
  logic [1:0]      op_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] div_q;
  logic [4:0]      count_q;
  logic            neg_q_f;
  logic            neg_r_f;
  logic            dz_f;

  logic            is_signed;
  logic [XLEN-1:0] shift_val;
  logic [XLEN-1:0] add_sum;
  logic            add_c;
  logic            q_bit;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] abs_rs1;
  logic [XLEN-1:0] abs_rs2;

  // DIV and REM have funct3[0] clear.
  assign is_signed = ~op_q[0];

  // Shift in the next dividend bit, then trial-subtract the divisor.
  assign shift_val = {rem_q[XLEN-2:0], quo_q[XLEN-1]};

  full_adder_32bit u_adder (
    .A_i   (shift_val),
    .Y_i   (~div_q),
    .C_i   (1'b1),
    .Sum_o (add_sum),
    .c_o   (add_c)
  );

  // A set remainder MSB means the shifted value overflowed 32 bits, so the
  // divisor always fits even when the adder reports a borrow.
  assign q_bit = rem_q[XLEN-1] | add_c;

  // Magnitudes of the raw operands, valid while in PREP; 0x80000000 stays as is.
  assign abs_rs1 = (is_signed && quo_q[XLEN-1]) ? -quo_q : quo_q;
  assign abs_rs2 = (is_signed && div_q[XLEN-1]) ? -div_q : div_q;

  // Divide-by-zero keeps the all-ones quotient the iteration naturally yields.
  assign quo_fix = (is_signed && neg_q_f && !dz_f) ? -quo_q : quo_q;
  assign rem_fix = (is_signed && neg_r_f) ? -rem_q : rem_q;

`ifdef DIV_FASTPATH_EN
  logic            fp_dz;
  logic            fp_ovf;
  logic [XLEN-1:0] fp_result;

  // Special cases detected on the raw operands still held in quo_q/div_q.
  assign fp_dz  = (div_q == '0);
  assign fp_ovf = is_signed && (quo_q == {1'b1, {(XLEN-1){1'b0}}}) &&
                  (div_q == {XLEN{1'b1}});

  // x/0: quotient all ones, remainder the dividend; overflow: quotient = dividend, remainder 0.
  always_comb begin
    fp_result = '0;
    if (fp_dz) begin
      fp_result = op_q[1] ? quo_q : {XLEN{1'b1}};
    end else begin
      fp_result = op_q[1] ? '0 : quo_q;
    end
  end
`endif

  // Control FSM with the datapath registers and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      op_q     <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      count_q  <= '0;
      neg_q_f  <= 1'b0;
      neg_r_f  <= 1'b0;
      dz_f     <= 1'b0;
      busy_o   <= 1'b0;
      valid_o  <= 1'b0;
      result_o <= '0;
    end else if (kill_i && state != S_IDLE) begin
      state   <= S_IDLE;
      busy_o  <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          valid_o <= 1'b0;
          if (start_i && !kill_i) begin
            op_q   <= op_i;
            quo_q  <= rs1_i;
            div_q  <= rs2_i;
            busy_o <= 1'b1;
            state  <= S_PREP;
          end
        end
        S_PREP: begin
`ifdef DIV_FASTPATH_EN
          if (fp_dz || fp_ovf) begin
            result_o <= fp_result;
            valid_o  <= 1'b1;
            state    <= S_DONE;
          end else begin
            neg_q_f <= quo_q[XLEN-1] ^ div_q[XLEN-1];
            neg_r_f <= quo_q[XLEN-1];
            dz_f    <= (div_q == '0);
            quo_q   <= abs_rs1;
            div_q   <= abs_rs2;
            rem_q   <= '0;
            count_q <= 5'd31;
            state   <= S_ITER;
          end
`else
          neg_q_f <= quo_q[XLEN-1] ^ div_q[XLEN-1];
          neg_r_f <= quo_q[XLEN-1];
          dz_f    <= (div_q == '0);
          quo_q   <= abs_rs1;
          div_q   <= abs_rs2;
          rem_q   <= '0;
          count_q <= 5'd31;
          state   <= S_ITER;
`endif
        end
        S_ITER: begin
          rem_q   <= q_bit ? add_sum : shift_val;
          quo_q   <= {quo_q[XLEN-2:0], q_bit};
          count_q <= count_q - 5'd1;
          if (count_q == 5'd0) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          result_o <= op_q[1] ? rem_fix : quo_fix;
          valid_o  <= 1'b1;
          state    <= S_DONE;
        end
        S_DONE: begin
          valid_o <= 1'b0;
          busy_o  <= 1'b0;
          state   <= S_IDLE;
        end
        default: begin
          valid_o <= 1'b0;
          busy_o  <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_div_unit.sv
// Testbench for riscv_div_unit: directed vector table, randomized operands
// against an arithmetic reference model, and abort/ignore/reset sequences.

module tb_riscv_div_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic        kill_i;
  logic        busy_o;
  logic        valid_o;
  logic [31:0] result_o;

  int checks = 0;
  int errors = 0;

  riscv_div_unit #(.XLEN(32)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .op_i     (op_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .kill_i   (kill_i),
    .busy_o   (busy_o),
    .valid_o  (valid_o),
    .result_o (result_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // RV32M semantics straight from the ISA rules.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (!op[0]) begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  function automatic int exp_latency(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
`ifdef DIV_FASTPATH_EN
    if (b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 2;
    return 35;
`else
    return 35;
`endif
  endfunction

  // Issue one request and wait (bounded) for valid_o; lat counts negedges after accept.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    @(negedge clk_i);
    start_i = 1'b1;
    op_i    = op;
    rs1_i   = a;
    rs2_i   = b;
    @(negedge clk_i);
    start_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 100) begin
      @(negedge clk_i);
      lat++;
    end
    if (!valid_o) lat = -1;
    res = result_o;
  endtask

  task automatic count_valid(input int n, output int seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      if (valid_o) seen++;
    end
  endtask

  initial begin
    logic [31:0] res;
    logic [31:0] last_exp;
    int          lat;
    int          seen;
    int          n;

    vecs[0]  = '{"divu_100_7",    2'b01, 32'd100,       32'd7,         32'd14};
    vecs[1]  = '{"remu_100_7",    2'b11, 32'd100,       32'd7,         32'd2};
    vecs[2]  = '{"div_m7_2",      2'b00, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
    vecs[3]  = '{"rem_m7_2",      2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
    vecs[4]  = '{"div_7_m2",      2'b00, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD};
    vecs[5]  = '{"rem_7_m2",      2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1};
    vecs[6]  = '{"divu_5_0",      2'b01, 32'd5,         32'd0,         32'hFFFF_FFFF};
    vecs[7]  = '{"div_m5_0",      2'b00, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF};
    vecs[8]  = '{"rem_m5_0",      2'b10, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB};
    vecs[9]  = '{"remu_5_0",      2'b11, 32'd5,         32'd0,         32'd5};
    vecs[10] = '{"div_ovf",       2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[11] = '{"rem_ovf",       2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
    vecs[12] = '{"divu_max_1",    2'b01, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF};
    vecs[13] = '{"divu_big_div",  2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1};
    vecs[14] = '{"remu_big_div",  2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE};
    vecs[15] = '{"div_min_2",     2'b00, 32'h8000_0000, 32'd2,         32'hC000_0000};

    rst_i   = 1'b1;
    start_i = 1'b0;
    kill_i  = 1'b0;
    op_i    = 2'b00;
    rs1_i   = '0;
    rs2_i   = '0;
    repeat (3) @(negedge clk_i);
    chk("reset_busy", {31'd0, busy_o}, 32'd0);
    chk("reset_valid", {31'd0, valid_o}, 32'd0);
    chk("reset_result", result_o, 32'd0);
    rst_i = 1'b0;

    // Directed table.
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
      chk({vecs[i].name, "_result"}, res, vecs[i].exp);
      chk({vecs[i].name, "_latency"}, 32'(lat), 32'(exp_latency(vecs[i].op, vecs[i].a, vecs[i].b)));
      @(negedge clk_i);
      chk({vecs[i].name, "_valid_pulse"}, {31'd0, valid_o}, 32'd0);
      chk({vecs[i].name, "_busy_fall"}, {31'd0, busy_o}, 32'd0);
    end

    // Randomized operands against the model.
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 15));
        3:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      run_op(op, a, b, res, lat);
      chk("rand_result", res, model(op, a, b));
      chk("rand_latency", 32'(lat), 32'(exp_latency(op, a, b)));
    end

    // Kill during ITER step 10: no strobe, result held.
    run_op(2'b01, 32'd100, 32'd7, res, lat);
    last_exp = 32'd14;
    chk("pre_kill_result", res, last_exp);
    @(negedge clk_i);
    start_i = 1'b1;
    op_i    = 2'b01;
    rs1_i   = 32'd1000;
    rs2_i   = 32'd3;
    @(negedge clk_i);
    start_i = 1'b0;
    n = 1;
    while (n < 10) begin
      @(negedge clk_i);
      n++;
    end
    chk("kill_busy_before", {31'd0, busy_o}, 32'd1);
    kill_i = 1'b1;
    @(negedge clk_i);
    kill_i = 1'b0;
    chk("kill_busy_after", {31'd0, busy_o}, 32'd0);
    chk("kill_result_held", result_o, last_exp);
    count_valid(40, seen);
    chk("kill_no_valid", 32'(seen), 32'd0);

    // Second start mid-operation is ignored.
    @(negedge clk_i);
    start_i = 1'b1;
    op_i    = 2'b01;
    rs1_i   = 32'd1000;
    rs2_i   = 32'd3;
    @(negedge clk_i);
    start_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 100) begin
      if (lat == 5) begin
        start_i = 1'b1;
        op_i    = 2'b11;
        rs1_i   = 32'd9;
        rs2_i   = 32'd9;
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk_i);
      lat++;
    end
    start_i = 1'b0;
    if (!valid_o) lat = -1;
    chk("restart_result", result_o, 32'd333);
    chk("restart_latency", 32'(lat), 32'd35);
    last_exp = 32'd333;
    count_valid(40, seen);
    chk("restart_no_second_valid", 32'(seen), 32'd0);

    // Kill and start together in IDLE: request dropped.
    @(negedge clk_i);
    start_i = 1'b1;
    kill_i  = 1'b1;
    op_i    = 2'b01;
    rs1_i   = 32'd50;
    rs2_i   = 32'd5;
    @(negedge clk_i);
    start_i = 1'b0;
    kill_i  = 1'b0;
    chk("kill_start_idle_busy", {31'd0, busy_o}, 32'd0);
    count_valid(40, seen);
    chk("kill_start_idle_no_valid", 32'(seen), 32'd0);
    chk("kill_start_idle_result", result_o, last_exp);

    // Asynchronous reset mid-ITER.
    @(negedge clk_i);
    start_i = 1'b1;
    op_i    = 2'b00;
    rs1_i   = 32'hFFFF_FF00;
    rs2_i   = 32'd3;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (14) @(negedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    chk("async_rst_busy", {31'd0, busy_o}, 32'd0);
    chk("async_rst_valid", {31'd0, valid_o}, 32'd0);
    chk("async_rst_result", result_o, 32'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    count_valid(40, seen);
    chk("async_rst_no_valid", 32'(seen), 32'd0);

    // Recovery after reset.
    run_op(2'b11, 32'd100, 32'd7, res, lat);
    chk("post_rst_result", res, 32'd2);
    chk("post_rst_latency", 32'(lat), 32'd35);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
